// File: rtl/usb_bus_bridge_if.sv
// rtl/usb_bus_bridge_if.sv - CPU, CSR bus and endpoint buffer signals of the USB bus bridge
interface usb_bus_bridge_if;
  logic        cpu_valid;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [11:0] bus_addr;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;
  logic        bus_cyc;
  logic        bus_we;
  logic        bus_ack;
  logic [8:0]  ep_tx_addr_0;
  logic [31:0] ep_tx_data_0;
  logic        ep_tx_we_0;
  logic [8:0]  ep_rx_addr_0;
  logic        ep_rx_re_0;
  logic [31:0] ep_rx_data_1;
  logic        err_timeout;
  logic        err_clr;

  // slave is the bridge itself; master is the surrounding CPU and USB core
  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, bus_dout, bus_ack, ep_rx_data_1, err_clr,
    output cpu_ready, cpu_rdata, bus_addr, bus_din, bus_cyc, bus_we,
           ep_tx_addr_0, ep_tx_data_0, ep_tx_we_0, ep_rx_addr_0, ep_rx_re_0, err_timeout
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, bus_dout, bus_ack, ep_rx_data_1, err_clr,
    input  cpu_ready, cpu_rdata, bus_addr, bus_din, bus_cyc, bus_we,
           ep_tx_addr_0, ep_tx_data_0, ep_tx_we_0, ep_rx_addr_0, ep_rx_re_0, err_timeout
  );
endinterface

// File: rtl/usb_bus_bridge.sv
// rtl/usb_bus_bridge.sv - CPU word bus to USB core CSR, TX buffer and RX buffer bridge
module usb_bus_bridge #(
  parameter int unsigned TIMEOUT = 63
) (
  input logic             clk,
  input logic             rst_n,
  usb_bus_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CSR, RXRD, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rx_pend_q, rx_pend_d;
  logic        cpu_ready_d;
  logic [31:0] cpu_rdata_d;
  logic [11:0] bus_addr_d;
  logic [15:0] bus_din_d;
  logic        bus_cyc_d, bus_we_d;
  logic [8:0]  tx_addr_d, rx_addr_d;
  logic [31:0] tx_data_d;
  logic        tx_we_d, rx_re_d;
  logic        err_d;

  logic [1:0]  region;
  logic        is_wr;
  logic        accept;
  logic        cnt_expired;

  assign region      = bus.cpu_addr[15:14];
  assign is_wr       = |bus.cpu_wstrb;
  // The cpu_ready cycle still sees cpu_valid high, so it must not start a new access
  assign accept      = bus.cpu_valid && !bus.cpu_ready;
  assign cnt_expired = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_pend_d   = (state_q == RXRD);
    cpu_ready_d = 1'b0;
    cpu_rdata_d = bus.cpu_rdata;
    bus_addr_d  = bus.bus_addr;
    bus_din_d   = bus.bus_din;
    bus_cyc_d   = bus.bus_cyc;
    bus_we_d    = bus.bus_we;
    tx_addr_d   = bus.ep_tx_addr_0;
    tx_data_d   = bus.ep_tx_data_0;
    tx_we_d     = 1'b0;
    rx_addr_d   = bus.ep_rx_addr_0;
    rx_re_d     = 1'b0;
    err_d       = bus.err_timeout & ~bus.err_clr;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (region)
            2'b00: begin
              bus_cyc_d  = 1'b1;
              bus_addr_d = bus.cpu_addr[11:0];
              bus_din_d  = bus.cpu_wdata[15:0];
              bus_we_d   = is_wr;
              cnt_d      = 8'd0;
              state_d    = CSR;
            end
            2'b01: begin
              if (is_wr) begin
                tx_we_d   = 1'b1;
                tx_addr_d = bus.cpu_addr[8:0];
                tx_data_d = bus.cpu_wdata;
              end
              cpu_rdata_d = 32'h0;
              state_d     = DONE;
            end
            2'b10: begin
              if (is_wr) begin
                cpu_rdata_d = 32'h0;
                state_d     = DONE;
              end else begin
                rx_re_d   = 1'b1;
                rx_addr_d = bus.cpu_addr[8:0];
                state_d   = RXRD;
              end
            end
            default: begin
              cpu_rdata_d = 32'h0;
              state_d     = DONE;
            end
          endcase
        end
      end
      CSR: begin
        // An acknowledge arriving on the expiry cycle takes precedence over the timeout
        if (bus.bus_ack) begin
          cpu_rdata_d = {16'h0, bus.bus_dout};
          bus_cyc_d   = 1'b0;
          bus_we_d    = 1'b0;
          state_d     = DONE;
        end else if (cnt_expired) begin
          cpu_rdata_d = 32'hFFFF_FFFF;
          bus_cyc_d   = 1'b0;
          bus_we_d    = 1'b0;
          err_d       = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RXRD: begin
        state_d = DONE;
      end
      DONE: begin
        // RX buffer data becomes valid the cycle after the read enable, i.e. here
        if (rx_pend_q) begin
          cpu_rdata_d = bus.ep_rx_data_1;
        end
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= 8'd0;
      rx_pend_q        <= 1'b0;
      bus.cpu_ready    <= 1'b0;
      bus.cpu_rdata    <= 32'h0;
      bus.bus_addr     <= 12'h0;
      bus.bus_din      <= 16'h0;
      bus.bus_cyc      <= 1'b0;
      bus.bus_we       <= 1'b0;
      bus.ep_tx_addr_0 <= 9'h0;
      bus.ep_tx_data_0 <= 32'h0;
      bus.ep_tx_we_0   <= 1'b0;
      bus.ep_rx_addr_0 <= 9'h0;
      bus.ep_rx_re_0   <= 1'b0;
      bus.err_timeout  <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rx_pend_q        <= rx_pend_d;
      bus.cpu_ready    <= cpu_ready_d;
      bus.cpu_rdata    <= cpu_rdata_d;
      bus.bus_addr     <= bus_addr_d;
      bus.bus_din      <= bus_din_d;
      bus.bus_cyc      <= bus_cyc_d;
      bus.bus_we       <= bus_we_d;
      bus.ep_tx_addr_0 <= tx_addr_d;
      bus.ep_tx_data_0 <= tx_data_d;
      bus.ep_tx_we_0   <= tx_we_d;
      bus.ep_rx_addr_0 <= rx_addr_d;
      bus.ep_rx_re_0   <= rx_re_d;
      bus.err_timeout  <= err_d;
    end
  end
endmodule

// File: doc/usb_bus_bridge.md
USB_BUS_BRIDGE -- requirements
Module: usb_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum cycles waiting for bus_ack before forced completion; legal range 1..255.
REQ-002 clk  input  1  single clock for all logic; the ep_clk input of the USB core is driven from this same clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_valid  input  1  CPU request; held high until cpu_ready is asserted.
REQ-005 cpu_addr  input  16  word address; [15:14] selects the region, [13:0] is the offset.
REQ-006 cpu_wdata  input  32  write data.
REQ-007 cpu_wstrb  input  4  byte strobes; any bit set means write, all zero means read.
REQ-008 cpu_ready  output  1  one-cycle completion pulse.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-010 bus_addr  output  12  CSR/EP-status address to the USB core.
REQ-011 bus_din  output  16  CSR write data.
REQ-012 bus_dout  input  16  CSR read data.
REQ-013 bus_cyc, bus_we  output  1 each  CSR cycle strobe and write flag.
REQ-014 bus_ack  input  1  CSR completion.
REQ-015 ep_tx_addr_0  output  9  TX buffer write address.
REQ-016 ep_tx_data_0  output  32  TX buffer write data.
REQ-017 ep_tx_we_0  output  1  TX buffer write enable.
REQ-018 ep_rx_addr_0  output  9  RX buffer read address.
REQ-019 ep_rx_re_0  output  1  RX buffer read enable.
REQ-020 ep_rx_data_1  input  32  RX buffer read data, valid one cycle after ep_rx_re_0.
REQ-021 err_timeout  output  1  sticky flag, set by a bus timeout.
REQ-022 err_clr  input  1  synchronous clear of err_timeout.

Function
REQ-023 Region map on cpu_addr[15:14]: 00 = CSR/EPS, 01 = TX buffer, 10 = RX buffer, 11 = unmapped.
REQ-024 FSM states: IDLE, CSR, RXRD, DONE; all outputs are registered.
REQ-025 IDLE with cpu_valid, region 00: next cycle bus_cyc=1, bus_addr=cpu_addr[11:0], bus_din=cpu_wdata[15:0], bus_we=|cpu_wstrb; go to CSR.
REQ-026 CSR: hold bus_cyc and all bus outputs stable until bus_ack.
  - On bus_ack: latch {16'h0, bus_dout} into cpu_rdata, drive bus_cyc=0 next cycle, go to DONE.
REQ-027 CSR timeout: 8-bit counter cleared on entry and incremented each cycle in CSR without bus_ack.
  - When the counter reaches TIMEOUT: drop bus_cyc, set cpu_rdata=32'hFFFFFFFF, set err_timeout, go to DONE.
  - bus_ack on the same cycle as the timeout wins; err_timeout is not set.
REQ-028 IDLE with cpu_valid, region 01, write: ep_tx_we_0=1 for exactly one cycle with ep_tx_addr_0=cpu_addr[8:0] and ep_tx_data_0=cpu_wdata (all strobes treated as full word); go to DONE with cpu_rdata=0.
REQ-029 Region 01 read, region 10 write, and region 11 any access: no side effect; go to DONE with cpu_rdata=0.
REQ-030 IDLE with cpu_valid, region 10, read: ep_rx_re_0=1 for one cycle with ep_rx_addr_0=cpu_addr[8:0]; go to RXRD.
  - RXRD: latch ep_rx_data_1 into cpu_rdata; go to DONE.
REQ-031 DONE: cpu_ready=1 for exactly one cycle with bus_cyc=0; go to IDLE.
  - IDLE does not accept a request on the cycle immediately after DONE, so bus_cyc is low for at least 2 cycles between CSR accesses.
REQ-032 Latencies from cpu_valid sampled in IDLE to cpu_ready:
  - TX write and unmapped access: 2 cycles.
  - RX read: 3 cycles.
  - CSR access: bus_ack cycle + 2 cycles.
REQ-033 cpu_rdata holds its value outside cpu_ready; ep_tx_we_0, ep_rx_re_0 and cpu_ready are never asserted simultaneously.
REQ-034 err_timeout: err_clr and a timeout in the same cycle leave err_timeout set.

Reset
REQ-035 rst_n low asynchronously forces: state=IDLE; cpu_ready, bus_cyc, bus_we, ep_tx_we_0, ep_rx_re_0, err_timeout = 0; cpu_rdata, bus_addr, bus_din, ep addresses and data = 0; timeout counter = 0.
REQ-036 Reset asserted mid-transaction aborts it with no cpu_ready; after rst_n rises the block accepts a request on the first clock.

Verification
REQ-037 CSR read of addr 0x0000 with bus_ack 3 cycles after bus_cyc rises and bus_dout=16'h8085 -> cpu_rdata=32'h00008085 with cpu_ready one cycle after bus_cyc falls.
REQ-038 Write to 0x4005 with wdata=32'hA5A5_1234 -> single-cycle ep_tx_we_0, addr=9'h005, data=32'hA5A51234; cpu_ready 2 cycles after accept.
REQ-039 Read of 0x8010 with the RX RAM model returning 32'hCAFEF00D -> ep_rx_re_0 with addr=9'h010; cpu_rdata=32'hCAFEF00D at 3 cycles.
REQ-040 CSR write with bus_ack never asserted, TIMEOUT=63 -> bus_cyc drops after 63 cycles, cpu_rdata=32'hFFFFFFFF, err_timeout=1; err_clr pulse -> 0.
REQ-041 Back-to-back CSR requests (cpu_valid held) -> bus_cyc low for ≥2 cycles between accesses, bus_addr stable throughout each cycle.
REQ-042 rst_n pulsed low while in CSR -> bus_cyc=0 immediately, no cpu_ready; the next request completes normally.
